// File: rtl/float_triple_pkg.sv
// Shared types and constants for float_triple_packer.
// FLEN/NE/NF normally come from the cvw config; the fallbacks cover standalone builds.
`ifndef FLEN
`define FLEN 64
`endif
`ifndef NE
`define NE 11
`endif
`ifndef NF
`define NF 52
`endif

package float_triple_pkg;

    localparam int unsigned FLEN = `FLEN;
    localparam int unsigned NE   = `NE;
    localparam int unsigned NF   = `NF;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    typedef logic [1:0] slot_idx_t;

    // +infinity: sign 0, exponent all ones, mantissa zero
    localparam logic [FLEN-1:0] FP_POS_INF = {1'b0, {NE{1'b1}}, {NF{1'b0}}};

endpackage

// File: rtl/float_triple_packer.sv
// Packs a valid/ready stream of FP words into triples for the 3-input sort FSM.
// Define FLOAT_TRIPLE_PACKER_PAD_INF_EN to pad flushed partial triples with +inf instead of dropping.
module float_triple_packer
    import float_triple_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      up_valid,
    input  logic [FLEN-1:0]           up_data,
    output logic                      up_ready,
    input  logic                      flush,
    output logic                      sort_valid,
    output logic [0:2][FLEN-1:0]      sort_unsorted,
    input  logic                      sort_busy,
    output logic [1:0]                fill_level,
    output logic [CNT_W-1:0]          triple_cnt
);

    state_e                 state_q, state_d;
    logic [1:0]             fill_q, fill_d;
    logic [0:2][FLEN-1:0]   slot_q, slot_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             fill_wr;
    slot_idx_t              wr_idx;

    assign wr_idx = fill_q;

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        slot_d     = slot_q;
        cnt_d      = cnt_q;
        up_ready   = 1'b0;
        sort_valid = 1'b0;
        fill_wr    = fill_q;
        unique case (state_q)
            ST_FILL: begin
                up_ready = 1'b1;
                if (up_valid) begin
                    slot_d[wr_idx] = up_data;
                    fill_wr        = fill_q + 2'd1;
                end
                // A same-cycle write lands first; flush then sees the updated level
                if (fill_wr == 2'd3) begin
                    state_d = ST_FULL;
                    fill_d  = 2'd3;
                end else if (flush && (fill_wr != 2'd0)) begin
`ifdef FLOAT_TRIPLE_PACKER_PAD_INF_EN
                    for (int i = 1; i < 3; i++) begin
                        if (i >= int'(fill_wr)) begin
                            slot_d[i] = FP_POS_INF;
                        end
                    end
                    state_d = ST_FULL;
                    fill_d  = 2'd3;
`else
                    fill_d  = 2'd0;
`endif
                end else begin
                    fill_d = fill_wr;
                end
            end
            ST_FULL: begin
                sort_valid = !sort_busy;
                up_ready   = !sort_busy;
                if (!sort_busy) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_FILL;
                    // The issue cycle doubles as the first fill cycle of the next triple
                    if (up_valid) begin
                        slot_d[0] = up_data;
                        fill_d    = 2'd1;
                    end else begin
                        fill_d    = 2'd0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            fill_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slot contents are don't-care after reset; fill_q gates their use
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign sort_unsorted = slot_q;
    assign fill_level    = fill_q;
    assign triple_cnt    = cnt_q;

endmodule

// File: doc/float_triple_packer.md
Name: float_triple_packer

Overview:
- Upstream feeder for the three-input FP sort FSM.
- Accepts a stream of single FLEN-bit floating-point words over a valid/ready handshake and packs them into triples.
- Issues each completed triple to the sorter's valid_in/unsorted interface only when the sorter is idle, using its busy output.
- Sustains one word per cycle, matching the sorter's 3-cycle acceptance interval.

Parameters:
- CNT_W, 16, width of the issued-triple counter.
- FLEN comes from the shared cvw config. It is a global define, not a module parameter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- up_valid  input  1  upstream word valid
- up_data  input  FLEN  upstream FP word
- up_ready  output  1  packer can accept up_data this cycle
- flush  input  1  request to close a partial triple
- sort_valid  output  1  drives sorter valid_in
- sort_unsorted  output  [0:2][FLEN-1:0]  drives sorter unsorted; slot 0 = oldest word
- sort_busy  input  1  sorter busy output
- fill_level  output  2  number of words held in the current triple, 0..3
- triple_cnt  output  CNT_W  count of triples issued; wraps modulo 2^CNT_W

Behaviour:
- Interface: clock port is clk; reset port is rst. Reset is synchronous, active-high, single clock domain.
- Reset values:
  - state = ST_FILL
  - fill_level = 0
  - triple_cnt = 0
  - sort_valid = 0
  - up_ready = 1
  - slot registers are don't-care
- State ST_FILL (fill_level 0..2):
  - up_ready = 1.
  - A transfer occurs when up_valid && up_ready. The word is written to slot[fill_level] and fill_level increments.
  - When the third word is written, go to ST_FULL with fill_level = 3.
- State ST_FULL:
  - sort_valid = !sort_busy. This is combinational; sort_unsorted comes straight from the slot registers.
  - Issue cycle = sort_valid high. On that cycle triple_cnt increments.
  - up_ready = !sort_busy, so a word presented on the issue cycle is accepted into slot[0]. Next state is ST_FILL with fill_level = 1 if a word was accepted, else 0.
  - If sort_busy is high: hold all slots, sort_valid = 0, up_ready = 0.
- sort_valid is never high outside ST_FULL and is never high while sort_busy = 1. Each triple is issued exactly once.
- Latency: third word accepted in cycle N gives sort_valid in cycle N+1 if the sorter is idle.
- Back-to-back: with continuous up_valid and a sorter that is idle every 3rd cycle, up_ready never deasserts after the first triple.
- Word order: slot 0 = first accepted word, slot 2 = last. The packer does no reordering.
- Flush:
  - Acts in ST_FILL only; ignored in ST_FULL and when fill_level = 0 after the same-cycle write.
  - If flush and a transfer occur in the same cycle, the word is written first, then flush applies to the updated fill_level.
  - If that write completes the triple, flush has no effect.
  - Without the optional feature, flush discards the partial triple: fill_level goes to 0 and nothing is issued.
- Reset mid-operation: rst overrides everything. A held triple is dropped, and sort_valid is 0 in the cycle after rst.
- triple_cnt wraps from 2^CNT_W-1 to 0 silently.

Optional Feature:
- Macro: FLOAT_TRIPLE_PACKER_PAD_INF_EN.
- When defined, flush with fill_level of 1 or 2 pads the empty slots with +infinity (sign 0, exponent all ones, mantissa 0). The state goes to ST_FULL and the padded triple is issued normally and counted in triple_cnt.
- Padding with +inf keeps the real words in sorted slots 0..fill_level-1 after sorting.
- When not defined, flush discards the partial triple as described above.

Decomposition:
- Package float_triple_pkg contains:
  - state enum {ST_FILL, ST_FULL}
  - FP_POS_INF localparam of width FLEN, built from the cvw NE/NF widths
  - slot index typedef, logic [1:0]
- No sub-module. The block is a single FSM plus slot registers and a counter.

Test Plan:
- Reset, then words 0x4008000000000000 (3.0), 0x3FF0000000000000 (1.0), 0x4000000000000000 (2.0) on consecutive cycles, sort_busy = 0 → sort_valid pulses one cycle after the third word with sort_unsorted = {3.0, 1.0, 2.0}; triple_cnt = 1.
- Third word accepted while sort_busy = 1 for 2 cycles → sort_valid stays 0 and up_ready = 0 during busy; sort_valid = 1 on the first cycle with sort_busy = 0, with slots unchanged.
- Stream of 9 continuous words with a sorter model that is busy 2 of every 3 cycles → up_ready = 1 on all 9 transfers after the first triple; 3 issues; triple_cnt = 3; order preserved.
- Two words (1.0, 2.0) then flush → without the macro: fill_level = 0, no sort_valid. With the macro: sort_unsorted = {1.0, 2.0, 0x7FF0000000000000} issued once.
- flush in the same cycle as the third word → normal issue of the 3 real words; no padding; triple_cnt increments by 1.
- rst asserted while in ST_FULL with sort_busy = 1 → next cycle fill_level = 0, sort_valid = 0, triple_cnt = 0; the held triple is never issued.
